// File: rtl/scanner_pkg.sv
// Shared types and defaults for the memory dump scanner.
package scanner_pkg;

  // Scanner FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } scan_state_e;

  localparam int unsigned DB_CYCLES_DEF   = 1_000_000;
  localparam int unsigned AUTO_CYCLES_DEF = 50_000_000;
  localparam int unsigned WORD_STEP       = 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Flip the stable level once DB_CYCLES consecutive samples disagree with it
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = stable_d & ~stable_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mem_dump_scanner.sv
// Browses data memory through its auxiliary read port: steps the address
// by button or timer, waits out the read latency and captures the word.
module mem_dump_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STEP        = WORD_STEP,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned AUTO_CYCLES = AUTO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              auto_en,
  input  logic              freeze,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [31:0]       disp_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic              busy
);

  localparam int unsigned TMR_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       disp_data_q, disp_data_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic              disp_valid_q, disp_valid_d;
  logic              busy_q, busy_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              pend_next_q, pend_next_d;
  logic              pend_prev_q, pend_prev_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic next_press, prev_press;
  logic auto_step_c, want_prev_c, want_next_c;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (RST),
    .btn_raw (btn_next),
    .press   (next_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
    .clk     (clk),
    .rst_n   (RST),
    .btn_raw (btn_prev),
    .press   (prev_press)
  );

  // Next-state logic: auto timer, step arbitration, read sequencing, pending presses
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    disp_data_d  = disp_data_q;
    disp_addr_d  = disp_addr_q;
    disp_valid_d = disp_valid_q;
    busy_d       = busy_q;
    wait_cnt_d   = wait_cnt_q;
    pend_next_d  = pend_next_q;
    pend_prev_d  = pend_prev_q;
    tmr_d        = '0;
    auto_step_c  = 1'b0;
    want_prev_c  = prev_press | pend_prev_q;
    want_next_c  = next_press | pend_next_q;

    // Timer only runs while idle and unfrozen; elsewhere it sits at zero
    if (state_q == ST_IDLE && auto_en && !freeze) begin
      if (tmr_q == TMR_W'(AUTO_CYCLES - 1)) begin
        auto_step_c = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!freeze && (want_prev_c || want_next_c || auto_step_c)) begin
          if (want_prev_c) begin
            rd_addr_d = rd_addr_q - ADDR_W'(STEP);
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(STEP);
          end
          disp_valid_d = 1'b0;
          pend_next_d  = 1'b0;
          pend_prev_d  = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy_d     = 1'b1;
        wait_cnt_d = 2'(RD_LAT);
        state_d    = (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q <= 2'd1) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      ST_CAPTURE: begin
        disp_data_d  = rd_data;
        disp_addr_d  = rd_addr_q;
        disp_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Presses during a read are remembered once; a simultaneous pair keeps prev only
    if (state_q != ST_IDLE) begin
      if (prev_press) begin
        pend_prev_d = 1'b1;
      end else if (next_press) begin
        pend_next_d = 1'b1;
      end
    end
  end

  // State registers; reset restarts with a read of address zero
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q      <= ST_ISSUE;
      rd_addr_q    <= '0;
      disp_data_q  <= '0;
      disp_addr_q  <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      wait_cnt_q   <= '0;
      pend_next_q  <= 1'b0;
      pend_prev_q  <= 1'b0;
      tmr_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      disp_data_q  <= disp_data_d;
      disp_addr_q  <= disp_addr_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_next_q  <= pend_next_d;
      pend_prev_q  <= pend_prev_d;
      tmr_q        <= tmr_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_addr  = disp_addr_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_dump_scanner.sv
// Directed bench for mem_dump_scanner with short debounce and auto periods.
module tb_mem_dump_scanner;

  logic        clk = 1'b0;
  logic        RST;
  logic        btn_next, btn_prev, auto_en, freeze;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] disp_data;
  logic [11:0] disp_addr;
  logic        disp_valid, busy;

  int errors = 0;
  int checks = 0;

  // Address-change and valid-rise monitor, updated on every tick
  int          cyc = 0;
  int          chg_cnt;
  int          rise_cyc;
  int          chg_cyc [8];
  logic [11:0] chg_addr [8];
  logic [11:0] prev_addr;
  logic        prev_valid;

  always #5 clk = ~clk;

  mem_dump_scanner #(
    .ADDR_W      (12),
    .STEP        (4),
    .RD_LAT      (1),
    .DB_CYCLES   (4),
    .AUTO_CYCLES (10)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .auto_en    (auto_en),
    .freeze     (freeze),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .disp_data  (disp_data),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  // Memory contents: 0x000 holds DEADBEEF, every other word is C0DE0 & address
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    if (a == 12'h000) return 32'hDEAD_BEEF;
    return {20'hC0DE0, a};
  endfunction

  // One-cycle synchronous read port
  always @(posedge clk) rd_data <= mem_word(rd_addr);

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_addr !== prev_addr) begin
      if (chg_cnt < 8) begin
        chg_addr[3'(chg_cnt)] = rd_addr;
        chg_cyc[3'(chg_cnt)]  = cyc;
      end
      chg_cnt++;
    end
    if (disp_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_addr  = rd_addr;
    prev_valid = disp_valid;
  endtask

  task automatic clear_mon();
    chg_cnt    = 0;
    rise_cyc   = -1;
    prev_addr  = rd_addr;
    prev_valid = disp_valid;
  endtask

  // Six-cycle press on the chosen buttons, then enough quiet time to settle
  task automatic pulse_btn(input logic n, input logic p);
    btn_next = n;
    btn_prev = p;
    repeat (6) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; freeze = 1'b0;
    repeat (3) tick();
    checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL reset_rd_addr: got %h want 000", rd_addr); end
    checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL reset_disp_data: got %h want 0", disp_data); end
    checks++; if (disp_addr !== 12'h000) begin errors++; $display("FAIL reset_disp_addr: got %h want 000", disp_addr); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    RST = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_issue_busy: got %b want 1", busy); end
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_early: got %b want 0", disp_valid); end
    tick();
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL reset_valid_3cyc: got %b want 1", disp_valid); end
    checks++; if (disp_addr !== 12'h000) begin errors++; $display("FAIL reset_cap_addr: got %h want 000", disp_addr); end
    checks++; if (disp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_cap_data: got %h want deadbeef", disp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_cap_busy: got %b want 0", busy); end
  endtask

  task automatic test_next_debounce();
    clear_mon();
    for (int i = 0; i < 40; i++) begin
      btn_next = (i < 3) || (i >= 7 && i < 13);
      tick();
    end
    btn_next = 1'b0;
    checks++; if (chg_cnt !== 1) begin errors++; $display("FAIL db_step_count: got %0d want 1", chg_cnt); end
    checks++; if (chg_addr[0] !== 12'h004) begin errors++; $display("FAIL db_rd_addr: got %h want 004", chg_addr[0]); end
    checks++; if (rise_cyc - chg_cyc[0] !== 3) begin errors++; $display("FAIL db_latency: got %0d want 3", rise_cyc - chg_cyc[0]); end
    checks++; if (disp_addr !== 12'h004) begin errors++; $display("FAIL db_disp_addr: got %h want 004", disp_addr); end
    checks++; if (disp_data !== 32'hC0DE_0004) begin errors++; $display("FAIL db_disp_data: got %h want c0de0004", disp_data); end
  endtask

  task automatic test_prev_wrap();
    pulse_btn(1'b0, 1'b1);
    checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL prev_to_zero: got %h want 000", rd_addr); end
    pulse_btn(1'b0, 1'b1);
    checks++; if (rd_addr !== 12'hFFC) begin errors++; $display("FAIL prev_wrap_addr: got %h want ffc", rd_addr); end
    checks++; if (disp_addr !== 12'hFFC) begin errors++; $display("FAIL prev_wrap_disp: got %h want ffc", disp_addr); end
    checks++; if (disp_data !== 32'hC0DE_0FFC) begin errors++; $display("FAIL prev_wrap_data: got %h want c0de0ffc", disp_data); end
    pulse_btn(1'b1, 1'b0);
    checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL next_wrap_addr: got %h want 000", rd_addr); end
    checks++; if (disp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL next_wrap_data: got %h want deadbeef", disp_data); end
  endtask

  task automatic test_hold();
    clear_mon();
    btn_next = 1'b1;
    repeat (40) tick();
    btn_next = 1'b0;
    repeat (20) tick();
    checks++; if (chg_cnt !== 1) begin errors++; $display("FAIL hold_steps: got %0d want 1", chg_cnt); end
    checks++; if (rd_addr !== 12'h004) begin errors++; $display("FAIL hold_addr: got %h want 004", rd_addr); end
  endtask

  task automatic test_auto();
    RST = 1'b0;
    repeat (2) tick();
    clear_mon();
    auto_en = 1'b1;
    RST = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (chg_cnt == 2) freeze = 1'b1;
    end
    checks++; if (chg_cnt !== 2) begin errors++; $display("FAIL auto_steps: got %0d want 2", chg_cnt); end
    checks++; if (chg_addr[0] !== 12'h004) begin errors++; $display("FAIL auto_first: got %h want 004", chg_addr[0]); end
    checks++; if (chg_addr[1] !== 12'h008) begin errors++; $display("FAIL auto_second: got %h want 008", chg_addr[1]); end
    checks++; if (chg_cyc[1] - chg_cyc[0] !== 13) begin errors++; $display("FAIL auto_period: got %0d want 13", chg_cyc[1] - chg_cyc[0]); end
    checks++; if (disp_valid !== 1'b1 || disp_addr !== 12'h008) begin errors++; $display("FAIL auto_freeze_capture: got v=%b a=%h want v=1 a=008", disp_valid, disp_addr); end
    auto_en = 1'b0;
    clear_mon();
    pulse_btn(1'b1, 1'b0);
    checks++; if (chg_cnt !== 0) begin errors++; $display("FAIL freeze_press: got %0d steps want 0", chg_cnt); end
    freeze = 1'b0;
    repeat (10) tick();
    checks++; if (rd_addr !== 12'h008) begin errors++; $display("FAIL unfreeze_addr: got %h want 008", rd_addr); end
  endtask

  task automatic test_pending();
    clear_mon();
    for (int i = 0; i < 30; i++) begin
      btn_prev = (i < 6);
      btn_next = (i >= 2 && i < 8);
      tick();
    end
    checks++; if (chg_cnt !== 2) begin errors++; $display("FAIL pend_steps: got %0d want 2", chg_cnt); end
    checks++; if (chg_addr[0] !== 12'h004) begin errors++; $display("FAIL pend_first: got %h want 004", chg_addr[0]); end
    checks++; if (chg_addr[1] !== 12'h008) begin errors++; $display("FAIL pend_second: got %h want 008", chg_addr[1]); end
    checks++; if (chg_cyc[1] - chg_cyc[0] !== 4) begin errors++; $display("FAIL pend_gap: got %0d want 4", chg_cyc[1] - chg_cyc[0]); end
    checks++; if (disp_data !== 32'hC0DE_0008) begin errors++; $display("FAIL pend_data: got %h want c0de0008", disp_data); end
  endtask

  task automatic test_simultaneous();
    clear_mon();
    pulse_btn(1'b1, 1'b1);
    repeat (5) tick();
    checks++; if (chg_cnt !== 1) begin errors++; $display("FAIL simul_steps: got %0d want 1", chg_cnt); end
    checks++; if (rd_addr !== 12'h004) begin errors++; $display("FAIL simul_addr: got %h want 004", rd_addr); end
    checks++; if (disp_addr !== 12'h004) begin errors++; $display("FAIL simul_disp: got %h want 004", disp_addr); end
  endtask

  task automatic test_rst_mid_read();
    btn_next = 1'b1;
    repeat (6) tick();
    btn_next = 1'b0;
    tick();
    checks++; if (rd_addr !== 12'h008) begin errors++; $display("FAIL rmr_step: got %h want 008", rd_addr); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmr_busy_wait: got %b want 1", busy); end
    RST = 1'b0;
    tick();
    checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL rmr_rd_addr: got %h want 000", rd_addr); end
    checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL rmr_disp_data: got %h want 0", disp_data); end
    checks++; if (disp_addr !== 12'h000) begin errors++; $display("FAIL rmr_disp_addr: got %h want 000", disp_addr); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rmr_disp_valid: got %b want 0", disp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy: got %b want 0", busy); end
    RST = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmr_issue: got %b want 1", busy); end
    tick();
    tick();
    checks++; if (disp_valid !== 1'b1 || disp_addr !== 12'h000) begin errors++; $display("FAIL rmr_recapture: got v=%b a=%h want v=1 a=000", disp_valid, disp_addr); end
    checks++; if (disp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmr_data: got %h want deadbeef", disp_data); end
  endtask

  initial begin
    test_reset();
    test_next_debounce();
    test_prev_wrap();
    test_hold();
    test_auto();
    test_pending();
    test_simultaneous();
    test_rst_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_dump_scanner.md
Name: mem_dump_scanner

Overview:
- Drives the data memory's auxiliary read port, the `in_addr`/`extra_dout` pair of the ME stage, as its reader, so memory contents can be browsed on the board while the CPU runs or is halted.
- Steps the address by hand (next/prev buttons) or automatically on a timer.
- Captures each returned word after the read latency and presents it with its address to the display selector.
- Sits beside the CPU top; its address output goes to `in_addr`, and its captured word goes to `change_type` in place of the raw read data.

Parameters:
- ADDR_W, 12, width of the byte address on the auxiliary port
- STEP, 4, address increment per step (one word)
- RD_LAT, 1, cycles from a stable address to valid `rd_data` (legal 0..3)
- DB_CYCLES, 20'd1_000_000, number of consecutive equal samples that accepts a button level
- AUTO_CYCLES, 26'd50_000_000, period between automatic steps

Ports:
- clk  in  1  system clock (the divided CPU clock domain)
- RST  in  1  synchronous, active-low reset
- btn_next  in  1  raw push button: advance the address
- btn_prev  in  1  raw push button: step the address back
- auto_en  in  1  level: enable timed auto-stepping
- freeze  in  1  level: hold the current address and captured data
- rd_addr  out  ADDR_W  address to the memory auxiliary read port
- rd_data  in  32  word returned by the memory auxiliary port
- disp_data  out  32  last captured word
- disp_addr  out  ADDR_W  address that `disp_data` belongs to
- disp_valid  out  1  high while `disp_data` matches `disp_addr`
- busy  out  1  high while a read is in flight

Behaviour:
- Reset applies on a clk edge while RST=0. All outputs go to 0: `rd_addr`, `disp_data`, `disp_addr`, `disp_valid`, `busy`.
  - FSM goes to ISSUE, so the word at 0x000 is read right after reset.
  - Debouncers and the auto timer clear.
- Debounce: each button passes through a 2-flop synchronizer and a counter. The stable level toggles only after DB_CYCLES consecutive samples that differ from it.
  - A press is the stable rising edge, one cycle wide.
  - Holding a button produces exactly one press.
- Auto timer counts only in IDLE with auto_en=1 and freeze=0. On reaching AUTO_CYCLES-1 it emits one step_next and reloads 0. Otherwise it holds 0.
- Step arithmetic is modulo 2^ADDR_W on the address bits:
  - next: `rd_addr + STEP`, so 0xFFC wraps to 0x000.
  - prev: `rd_addr - STEP`, so 0x000 wraps to 0xFFC.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE: freeze=1 ignores all step sources. Otherwise `prev_press` has top priority, then `next_press`, then the auto step. Any step updates `rd_addr`, clears `disp_valid`, and moves to ISSUE.
  - ISSUE: sets busy=1 and loads the wait counter with RD_LAT. If RD_LAT=0, goes straight to CAPTURE; otherwise goes to WAIT.
  - WAIT: decrements the counter and goes to CAPTURE when it reaches 1.
  - CAPTURE: registers `disp_data <= rd_data` and `disp_addr <= rd_addr`, sets disp_valid=1 and busy=0, and returns to IDLE.
- Press during a read: presses arriving while not in IDLE are latched in a one-deep pending flag per direction.
  - On return to IDLE, a pending prev wins over a pending next.
  - Both pending flags clear when either one is serviced.
  - Further presses beyond one per direction are dropped.
- Simultaneous next and prev presses in the same cycle: prev is taken and next is discarded.
- `rd_addr` stays stable from ISSUE through CAPTURE. It changes only on the IDLE→ISSUE step.
- Latency from press to `disp_valid` = 1 + RD_LAT + 1 cycles: the IDLE step, then ISSUE/WAIT, then CAPTURE.
- freeze=1 arriving mid-read does not abort the read; the capture still completes, and then the FSM stays in IDLE.
- RST low mid-read aborts the read and applies reset values next edge.

Decomposition:
- A shared package `scanner_pkg` holds:
  - the FSM state enum (2 bits);
  - the DB_CYCLES and AUTO_CYCLES defaults;
  - a WORD_STEP constant of 4.
- One sub-module, `btn_debounce` (synchronizer plus counter plus rising-edge pulse), instantiated twice.
- Top-level FSM, pending flags, auto timer and address arithmetic stay in `mem_dump_scanner`.

Test Plan:
- Reset then release with DB_CYCLES=4, RD_LAT=1, memory word 0x000 = 0xDEADBEEF → `disp_valid`=1 three cycles after release, with `disp_addr`=0x000 and `disp_data`=0xDEADBEEF.
- btn_next held for 3 cycles, then a clean press lasting DB_CYCLES+2 cycles → the bounce is ignored and exactly one step occurs: `rd_addr` goes 0x000→0x004, and `disp_data` equals mem[0x004] after the stated latency.
- btn_prev pressed at 0x000 → `rd_addr`=0xFFC and `disp_addr`=0xFFC; then btn_next → 0x000.
- auto_en=1 with AUTO_CYCLES=10, then freeze=1 after two steps → the address advances 0x000→0x004→0x008 and then holds.
- next pressed during WAIT, then prev pressed in the same cycle as a second next → a pending next is serviced after CAPTURE; the simultaneous pair resolves to prev.
- RST asserted during WAIT → on the next edge all outputs are 0 and the FSM is in ISSUE; the first capture after release is address 0x000.
